// File: rtl/ibis_tmds_pkg.sv
// Shared types, code tables and the transition-minimising helper for the TMDS encoder.
// IBIS_TMDS_TERC4_EN adds the TERC4 data-island code table.
package ibis_tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODE [0:3] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    // Entry 0 is used on even lanes (blue/red), entry 1 on odd lanes (green).
    localparam logic [9:0] GUARD_CODE [0:1] = '{10'b1011001100, 10'b0100110011};

`ifdef IBIS_TMDS_TERC4_EN
    localparam logic [9:0] TERC4_CODE [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

    // Returns {q_m[8:0], bal[4:0]}; bal is the signed ones-minus-zeros count of q_m[7:0].
    function automatic logic [13:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic [3:0] nq;
        logic       use_xnor;
        logic [8:0] q;
        logic [4:0] bal;
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + 4'(d[i]);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        nq = '0;
        for (int i = 0; i < 8; i++) nq = nq + 4'(q[i]);
        bal = 5'({1'b0, nq, 1'b0} - 6'd8);
        return {q, bal};
    endfunction

endpackage

// File: rtl/ibis_tmds_qm_stage.sv
// First pipeline stage for one TMDS lane: q_m/balance per symbol plus registered sideband.
module ibis_tmds_qm_stage
    import ibis_tmds_pkg::*;
#(
    parameter int SYMBOLS = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  tmds_mode_t             mode,
    input  logic [SYMBOLS*8-1:0]   data,
    input  logic [1:0]             control,
    input  logic [SYMBOLS*4-1:0]   terc4,
    output logic [SYMBOLS*9-1:0]   qm_p1,
    output logic [SYMBOLS*5-1:0]   bal_p1,
    output tmds_mode_t             mode_p1,
    output logic [1:0]             control_p1,
    output logic [SYMBOLS*4-1:0]   terc4_p1
);

    logic [SYMBOLS*9-1:0] qm_nx;
    logic [SYMBOLS*5-1:0] bal_nx;

    always_comb begin
        qm_nx  = '0;
        bal_nx = '0;
        for (int s = 0; s < SYMBOLS; s++)
            {qm_nx[s*9 +: 9], bal_nx[s*5 +: 5]} = tmds_qm(data[s*8 +: 8]);
    end

    // Stage 1 register: a reset sample decodes as control code 00.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            qm_p1      <= '0;
            bal_p1     <= '0;
            mode_p1    <= MODE_CTRL;
            control_p1 <= '0;
            terc4_p1   <= '0;
        end else if (enable) begin
            qm_p1      <= qm_nx;
            bal_p1     <= bal_nx;
            mode_p1    <= mode;
            control_p1 <= control;
            terc4_p1   <= terc4;
        end
    end

endmodule

// File: rtl/ibis_tmds_encoder_multi.sv
// Multi-lane, multi-symbol TMDS encoder: stage 1 per lane, disparity chain and output mux here.
// IBIS_TMDS_TERC4_EN enables TERC4 island encoding; otherwise mode 10 behaves as control.
module ibis_tmds_encoder_multi
    import ibis_tmds_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int SYMBOLS  = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             enable,
    input  logic [1:0]                       mode,
    input  logic [CHANNELS*SYMBOLS*8-1:0]    data,
    input  logic [CHANNELS*2-1:0]            control,
    input  logic [CHANNELS*SYMBOLS*4-1:0]    terc4,
    output logic [CHANNELS*SYMBOLS*10-1:0]   out_parallel,
    output logic                             out_valid,
    output logic [CHANNELS*5-1:0]            debug_bias
);

    logic [CHANNELS-1:0][SYMBOLS*9-1:0]  qm_p1;
    logic [CHANNELS-1:0][SYMBOLS*5-1:0]  bal_p1;
    tmds_mode_t                          mode_p1 [CHANNELS];
    logic [CHANNELS-1:0][1:0]            control_p1;
    logic [CHANNELS-1:0][SYMBOLS*4-1:0]  terc4_p1;

    logic [CHANNELS-1:0][SYMBOLS*10-1:0] out_nx, out_p2;
    logic [CHANNELS-1:0][4:0]            bias_nx, bias_p2;
    logic                                vld_p1, vld_p2;

    logic signed [4:0] b_w, bl_w;
    logic        [8:0] q_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        ibis_tmds_qm_stage #(.SYMBOLS(SYMBOLS)) u_qm (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .enable     (enable),
            .mode       (tmds_mode_t'(mode)),
            .data       (data[c*SYMBOLS*8 +: SYMBOLS*8]),
            .control    (control[c*2 +: 2]),
            .terc4      (terc4[c*SYMBOLS*4 +: SYMBOLS*4]),
            .qm_p1      (qm_p1[c]),
            .bal_p1     (bal_p1[c]),
            .mode_p1    (mode_p1[c]),
            .control_p1 (control_p1[c]),
            .terc4_p1   (terc4_p1[c])
        );
    end

`ifndef IBIS_TMDS_TERC4_EN
    logic unused_terc4;
    assign unused_terc4 = ^terc4_p1;
`endif

    // Symbols are chained in time order so each one sees the disparity left by its predecessor.
    always_comb begin
        out_nx  = '0;
        bias_nx = '0;
        b_w     = '0;
        bl_w    = '0;
        q_w     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            b_w = $signed(bias_p2[c]);
            for (int s = 0; s < SYMBOLS; s++) begin
                q_w  = qm_p1[c][s*9 +: 9];
                bl_w = $signed(bal_p1[c][s*5 +: 5]);
                case (mode_p1[c])
                    MODE_VIDEO: begin
                        if (b_w == 5'sd0 || bl_w == 5'sd0) begin
                            out_nx[c][s*10 +: 10] = {~q_w[8], q_w[8], q_w[8] ? q_w[7:0] : ~q_w[7:0]};
                            b_w = q_w[8] ? b_w + bl_w : b_w - bl_w;
                        end else if (b_w[4] == bl_w[4]) begin
                            out_nx[c][s*10 +: 10] = {1'b1, q_w[8], ~q_w[7:0]};
                            b_w = b_w + (q_w[8] ? 5'sd2 : 5'sd0) - bl_w;
                        end else begin
                            out_nx[c][s*10 +: 10] = {1'b0, q_w[8], q_w[7:0]};
                            b_w = b_w + bl_w - (q_w[8] ? 5'sd0 : 5'sd2);
                        end
                    end
                    MODE_GUARD: begin
                        out_nx[c][s*10 +: 10] = (c % 2 == 0) ? GUARD_CODE[0] : GUARD_CODE[1];
                        b_w = '0;
                    end
`ifdef IBIS_TMDS_TERC4_EN
                    MODE_TERC4: begin
                        out_nx[c][s*10 +: 10] = TERC4_CODE[terc4_p1[c][s*4 +: 4]];
                        b_w = '0;
                    end
`endif
                    default: begin
                        out_nx[c][s*10 +: 10] = CTRL_CODE[control_p1[c]];
                        b_w = '0;
                    end
                endcase
            end
            bias_nx[c] = b_w;
        end
    end

    // Stage 2 register: encoded words, per-lane disparity and the fill indicator.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_p2  <= '0;
            bias_p2 <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else if (enable) begin
            out_p2  <= out_nx;
            bias_p2 <= bias_nx;
            vld_p1  <= 1'b1;
            vld_p2  <= vld_p1;
        end
    end

    assign out_parallel = out_p2;
    assign debug_bias   = bias_p2;
    assign out_valid    = vld_p2;

endmodule

// File: tb/tb_ibis_tmds_encoder_multi.sv
// Bench for ibis_tmds_encoder_multi: SYMBOLS=1 and SYMBOLS=2 instances against a DVI-style reference model.
module tb_ibis_tmds_encoder_multi;

    localparam logic [9:0] TB_CTRL  [0:3] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TB_GUARD [0:1] = '{10'b1011001100, 10'b0100110011};
    localparam logic [9:0] TB_TERC4 [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [5:0]  control = '0;
    logic [23:0] data_s1 = '0;
    logic [11:0] terc4_s1 = '0;
    logic [47:0] data_s2 = '0;
    logic [23:0] terc4_s2 = '0;
    logic [29:0] out_s1;
    logic [59:0] out_s2;
    logic        valid_s1, valid_s2;
    logic [14:0] bias_s1, bias_s2;

    int checks = 0;
    int failures = 0;

    // Reference state: [instance][lane][symbol]; instance i carries i+1 symbols per lane.
    logic [9:0] exp_pend [2][3][2];
    logic [9:0] exp_out  [2][3][2];
    int         pend_bias [2][3];
    int         out_bias  [2][3];
    int         run_bias  [2][3];
    int         fill;

    always #5 aclk = ~aclk;

    ibis_tmds_encoder_multi #(.CHANNELS(3), .SYMBOLS(1)) dut_s1 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
        .data(data_s1), .control(control), .terc4(terc4_s1),
        .out_parallel(out_s1), .out_valid(valid_s1), .debug_bias(bias_s1)
    );

    ibis_tmds_encoder_multi #(.CHANNELS(3), .SYMBOLS(2)) dut_s2 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
        .data(data_s2), .control(control), .terc4(terc4_s2),
        .out_parallel(out_s2), .out_valid(valid_s2), .debug_bias(bias_s2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // DVI formulation: counts ones/zeros of q_m and tracks the running count as an integer.
    function automatic logic [9:0] enc_video(input logic [7:0] d, input int cnt_in, output int cnt_out);
        int n1d, n1q, n0q;
        logic [8:0] q;
        n1d = $countones(d);
        q[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        n1q = $countones(q[7:0]);
        n0q = 8 - n1q;
        if (cnt_in == 0 || n1q == n0q) begin
            cnt_out = q[8] ? cnt_in + n1q - n0q : cnt_in + n0q - n1q;
            return {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
            cnt_out = cnt_in + 2 * int'(q[8]) + n0q - n1q;
            return {1'b1, q[8], ~q[7:0]};
        end else begin
            cnt_out = cnt_in - 2 * int'(!q[8]) + n1q - n0q;
            return {1'b0, q[8], q[7:0]};
        end
    endfunction

    task automatic model_encode(input int inst);
        int nsym;
        int cnt;
        logic [7:0] d;
        logic [3:0] t;
        logic [1:0] ctl;
        nsym = inst + 1;
        for (int c = 0; c < 3; c++) begin
            cnt = run_bias[inst][c];
            ctl = control[c*2 +: 2];
            for (int s = 0; s < nsym; s++) begin
                d = (inst == 0) ? data_s1[c*8 +: 8] : data_s2[(c*2+s)*8 +: 8];
                t = (inst == 0) ? terc4_s1[c*4 +: 4] : terc4_s2[(c*2+s)*4 +: 4];
                case (mode)
                    2'b01: exp_pend[inst][c][s] = enc_video(d, cnt, cnt);
                    2'b11: begin exp_pend[inst][c][s] = TB_GUARD[c % 2]; cnt = 0; end
`ifdef IBIS_TMDS_TERC4_EN
                    2'b10: begin exp_pend[inst][c][s] = TB_TERC4[t]; cnt = 0; end
`else
                    2'b10: begin exp_pend[inst][c][s] = TB_CTRL[ctl]; cnt = 0; end
`endif
                    default: begin exp_pend[inst][c][s] = TB_CTRL[ctl]; cnt = 0; end
                endcase
            end
            run_bias[inst][c]  = cnt;
            pend_bias[inst][c] = cnt;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) begin
                for (int s = 0; s < 2; s++) begin
                    exp_out[i][c][s]  = '0;
                    exp_pend[i][c][s] = TB_CTRL[0];
                end
                out_bias[i][c] = 0;
                pend_bias[i][c] = 0;
                run_bias[i][c] = 0;
            end
        fill = 0;
    endtask

    task automatic model_advance();
        exp_out  = exp_pend;
        out_bias = pend_bias;
        if (fill < 2) fill++;
        model_encode(0);
        model_encode(1);
    endtask

    function automatic logic [63:0] exp_bus(input int inst);
        logic [63:0] v;
        int nsym;
        v = '0;
        nsym = inst + 1;
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < nsym; s++) v[(c*nsym+s)*10 +: 10] = exp_out[inst][c][s];
        return v;
    endfunction

    function automatic logic [63:0] exp_bias(input int inst);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 3; c++) v[c*5 +: 5] = 5'(out_bias[inst][c]);
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":out_s1"},   64'(out_s1),   exp_bus(0));
        chk({tag, ":out_s2"},   64'(out_s2),   exp_bus(1));
        chk({tag, ":bias_s1"},  64'(bias_s1),  exp_bias(0));
        chk({tag, ":bias_s2"},  64'(bias_s2),  exp_bias(1));
        chk({tag, ":valid_s1"}, 64'(valid_s1), 64'(fill >= 2));
        chk({tag, ":valid_s2"}, 64'(valid_s2), 64'(fill >= 2));
    endtask

    task automatic cycle(input logic en, input string tag);
        enable = en;
        @(posedge aclk);
        if (en) model_advance();
        @(negedge aclk);
        check_all(tag);
    endtask

    task automatic randomize_inputs();
        data_s1  = 24'($urandom);
        data_s2  = 48'({$urandom, $urandom});
        terc4_s1 = 12'($urandom);
        terc4_s2 = 24'($urandom);
        control  = 6'($urandom);
        mode     = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
    endtask

    initial begin
        model_reset();
        #1 aresetn = 1'b0;
        #3 check_all("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        mode = 2'b01;
        data_s1 = '0;
        data_s2 = '0;

        cycle(1'b1, "fill1");
        cycle(1'b1, "vid0a");
        chk("t1_sym_a",  64'(out_s1[9:0]),   64'(10'b0100000000));
        chk("t1_bias_a", 64'(bias_s1[4:0]),  64'(5'b11000));
        chk("t2_pair",   64'(out_s2[19:0]),  64'({10'b1111111111, 10'b0100000000}));
        chk("t2_bias",   64'(bias_s2[4:0]),  64'(5'd2));
        cycle(1'b1, "vid0b");
        chk("t1_sym_b",  64'(out_s1[9:0]),   64'(10'b1111111111));
        chk("t1_bias_b", 64'(bias_s1[4:0]),  64'(5'd2));

        mode = 2'b00;
        control = 6'b010101;
        cycle(1'b1, "ctl_in");
        mode = 2'b01;
        cycle(1'b1, "ctl_out");
        chk("t3_ctrl_s1", 64'(out_s1), 64'({3{10'b0010101011}}));
        chk("t3_ctrl_s2", 64'(out_s2), 64'({6{10'b0010101011}}));
        chk("t3_bias",    64'(bias_s1), 64'(0));
        cycle(1'b1, "ctl_vid");
        chk("t3_restart", 64'(out_s1[9:0]), 64'(10'b0100000000));

        mode = 2'b11;
        cycle(1'b1, "grd_in");
        mode = 2'b01;
        cycle(1'b1, "grd_out");
        chk("t4_guard", 64'(out_s1), 64'({10'b1011001100, 10'b0100110011, 10'b1011001100}));

        mode = 2'b10;
        terc4_s1 = '0;
        control = 6'b010101;
        cycle(1'b1, "terc_in");
        mode = 2'b01;
        cycle(1'b1, "terc_out");
`ifdef IBIS_TMDS_TERC4_EN
        chk("t5_terc4", 64'(out_s1[9:0]), 64'(10'b1010011100));
`else
        chk("t5_terc4", 64'(out_s1[9:0]), 64'(10'b0010101011));
`endif

        for (int n = 0; n < 200; n++) begin
            randomize_inputs();
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, "rand");
        end

        for (int n = 0; n < 5; n++) begin
            randomize_inputs();
            cycle(1'b0, "stall");
        end

        randomize_inputs();
        cycle(1'b1, "pre_rst");
        #2 aresetn = 1'b0;
        model_reset();
        #1 check_all("mid_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        check_all("rst_rel");
        mode = 2'b01;
        data_s1 = '0;
        data_s2 = '0;
        cycle(1'b1, "lat1");
        cycle(1'b1, "lat2");
        chk("t6_latency", 64'(out_s1[9:0]), 64'(10'b0100000000));

        for (int n = 0; n < 150; n++) begin
            randomize_inputs();
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, "rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
